// File: rtl/nibble_serial_adder_pkg.sv
// ============================================================================
// Module      : nibble_serial_adder_pkg
// Description : Shared slice width and state encoding for the nibble-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/nibble_serial_adder_ripple.sv
// ============================================================================
// Module      : ripple_adder
// Description : Combinational 4-bit ripple-carry adder cell (a + b + cin).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                c
);

    logic w_carry;

    always_comb begin
        w_carry = cin;
        s       = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]    = a[i] ^ b[i] ^ w_carry;
            w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
        c = w_carry;
    end

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module      : nibble_serial_adder
// Description : Multi-cycle WIDTH-bit adder, one nibble per clock, valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t            r_state_q, w_state_d;
    logic [IDX_W-1:0]  r_idx_q,   w_idx_d;
    logic              r_carry_q, w_carry_d;
    logic [WIDTH-1:0]  r_a_q,     w_a_d;
    logic [WIDTH-1:0]  r_b_q,     w_b_d;
    logic [WIDTH-1:0]  r_sum_q,   w_sum_d;
    logic              r_cout_q,  w_cout_d;
    logic              r_ovf_q,   w_ovf_d;

    logic [NIBBLE_W-1:0] w_cell_a, w_cell_b, w_cell_s;
    logic                w_cell_c;

    assign w_cell_a = r_a_q[r_idx_q*NIBBLE_W +: NIBBLE_W];
    assign w_cell_b = r_b_q[r_idx_q*NIBBLE_W +: NIBBLE_W];

    ripple_adder u_cell (
        .a   (w_cell_a),
        .b   (w_cell_b),
        .cin (r_carry_q),
        .s   (w_cell_s),
        .c   (w_cell_c)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        w_carry_d = r_carry_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_sum_d   = r_sum_q;
        w_cout_d  = r_cout_q;
        w_ovf_d   = r_ovf_q;
        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_a_d     = a;
                    w_b_d     = b;
                    w_carry_d = cin;
                    w_idx_d   = '0;
                    w_sum_d   = '0;
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                w_sum_d[r_idx_q*NIBBLE_W +: NIBBLE_W] = w_cell_s;
                w_carry_d = w_cell_c;
                if (r_idx_q == LAST_IDX) begin
                    // Top slice's sum MSB is the final sign bit of the result.
                    w_cout_d  = w_cell_c;
                    w_ovf_d   = (r_a_q[WIDTH-1] == r_b_q[WIDTH-1]) &&
                                (w_cell_s[NIBBLE_W-1] != r_a_q[WIDTH-1]);
                    w_idx_d   = '0;
                    w_state_d = ST_DONE;
                end else begin
                    w_idx_d = r_idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= ST_IDLE;
            r_idx_q   <= '0;
            r_carry_q <= 1'b0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_sum_q   <= '0;
            r_cout_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_carry_q <= w_carry_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_sum_q   <= w_sum_d;
            r_cout_q  <= w_cout_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    assign in_ready  = (r_state_q == ST_IDLE);
    assign out_valid = (r_state_q == ST_DONE);
    assign sum       = r_sum_q;
    assign cout      = r_cout_q;
    assign ovf       = r_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module      : tb_nibble_serial_adder
// Description : Scoreboard bench for nibble_serial_adder at WIDTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    // {ovf, cout, sum}
    logic [WIDTH+1:0] exp_q[$];

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic ci);
        logic [WIDTH:0] t;
        logic           v;
        t = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        v = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        return {v, t[WIDTH], t[WIDTH-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for acceptance, push expectation; returns after accept edge.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
        int n;
        a = x; b = y; cin = ci; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        exp_q.push_back(model(x, y, ci));
        tick();
        in_valid = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    endtask

    // Wait for out_valid, compare against scoreboard, optionally check latency, then take.
    task automatic receive(input string name, input int want_lat);
        int n;
        logic [WIDTH+1:0] e;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
            return;
        end
        if (want_lat >= 0) begin
            checks++;
            if (n !== want_lat) begin
                errors++;
                $display("FAIL %s_latency: got %0d required %0d", name, n, want_lat);
            end
        end
        e = exp_q.pop_front();
        checks++;
        if ({ovf, cout, sum} !== e) begin
            errors++;
            $display("FAIL %s_result: got ovf=%b cout=%b sum=%h required ovf=%b cout=%b sum=%h",
                     name, ovf, cout, sum, e[WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_take: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b sum=%h cout=%b ovf=%b required 0", out_valid, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        send(16'h1234, 16'h4321, 1'b0);
        receive("basic", 4);
        send(16'hFFFF, 16'h0001, 1'b0);
        receive("carry_chain", 4);
        send(16'h7FFF, 16'h0000, 1'b1);
        receive("ovf_pos", 4);
        send(16'h8000, 16'h8000, 1'b0);
        receive("ovf_neg", 4);
    endtask

    task automatic test_backpressure();
        logic [WIDTH+1:0] held;
        int n;
        send(16'hA5A5, 16'h5A5A, 1'b1);
        // Foreign operands pulsed during RUN must not be taken.
        a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        held = {ovf, cout, sum};
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, cout, sum} !== held) begin
                errors++;
                $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b value=%h required 1/0/%h",
                         i, out_valid, in_ready, {ovf, cout, sum}, held);
            end
        end
        in_valid = 1'b0;
        receive("backpressure", -1);
        repeat (6) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL no_extra_result: out_valid=%b required 0", out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: sum=%h cout=%b ovf=%b out_valid=%b required 0", sum, cout, ovf, out_valid);
        end
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_drop: out_valid=%b required 0", out_valid);
            end
        end
        send(16'h0001, 16'h0002, 1'b0);
        receive("after_reset", 4);
    endtask

    task automatic test_back_to_back();
        int done, cyc, last_acc, acc_n;
        logic [WIDTH+1:0] e;
        out_ready = 1'b1;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        in_valid = 1'b1;
        done = 0; cyc = 0; last_acc = -1; acc_n = 0;
        while (done < 1000 && cyc < 20000) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({ovf, cout, sum} !== e) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got %h required %h", done, {ovf, cout, sum}, e);
                end
                done++;
            end
            if (in_ready && acc_n < 1000) begin
                exp_q.push_back(model(a, b, cin));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== 6) begin
                        errors++;
                        $display("FAIL b2b_interval: got %0d required 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                acc_n++;
                tick();
                cyc++;
                a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
            end else begin
                tick();
                cyc++;
            end
        end
        checks++;
        if (done !== 1000) begin
            errors++;
            $display("FAIL b2b_count: got %0d results required 1000", done);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
